// File: rtl/mc_sequencer.sv
// Multi-cycle Moore control sequencer for the Gforce MIPS datapath (R-type, lw, sw, beq).
// Optional retired-instruction counter is built only when GFORCE_SEQ_RETIRE_CNT_EN is defined.
module mc_sequencer #(
   parameter int MEM_LAT = 1,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [31:0]      instrword,
   input  logic             instr_valid,
   output logic             instr_ready,
   output logic             ir_write,
   output logic             reg_dst,
   output logic             alu_src,
   output logic [1:0]       alu_op,
   output logic             mem_read,
   output logic             mem_write,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             branch,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] retired_cnt
);

   // Handshake: a word transfers on a posedge where instr_valid & instr_ready;
   // the source holds instrword while instr_ready is low.

   localparam logic [3:0] S_IDLE     = 4'd0;
   localparam logic [3:0] S_DECODE   = 4'd1;
   localparam logic [3:0] S_RTYPE_EX = 4'd2;
   localparam logic [3:0] S_RTYPE_WB = 4'd3;
   localparam logic [3:0] S_MEMADR   = 4'd4;
   localparam logic [3:0] S_MEMRD    = 4'd5;
   localparam logic [3:0] S_MEMWB    = 4'd6;
   localparam logic [3:0] S_MEMWR    = 4'd7;
   localparam logic [3:0] S_BEQ_EX   = 4'd8;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic [3:0] wait_cnt;
   logic [5:0] op_q;
   logic       accept;
   logic       unused_instr_bits;

   // Only the opcode field drives sequencing; the rest feeds the datapath directly.
   assign unused_instr_bits = ^instrword[25:0];

   assign instr_ready = !reset && (state == S_IDLE);
   assign accept      = instr_valid && instr_ready;
   assign ir_write    = accept;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (accept) state_nxt = S_DECODE;
         S_DECODE: begin
            case (op_q)
               OP_RTYPE:     state_nxt = S_RTYPE_EX;
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_BEQ:       state_nxt = S_BEQ_EX;
               default:      state_nxt = S_IDLE;
            endcase
         end
         S_RTYPE_EX: state_nxt = S_RTYPE_WB;
         S_RTYPE_WB: state_nxt = S_IDLE;
         S_MEMADR:   state_nxt = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:    if (wait_cnt == 4'd0) state_nxt = S_MEMWB;
         S_MEMWB:    state_nxt = S_IDLE;
         S_MEMWR:    if (wait_cnt == 4'd0) state_nxt = S_IDLE;
         S_BEQ_EX:   state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
         op_q     <= 6'd0;
      end else begin
         state <= state_nxt;
         if (accept) op_q <= instrword[31:26];
         // Counter is preloaded while in MEMADR so the memory state starts with it valid.
         if (state == S_MEMADR)
            wait_cnt <= LAT_LOAD;
         else if (((state == S_MEMRD) || (state == S_MEMWR)) && (wait_cnt != 4'd0))
            wait_cnt <= wait_cnt - 4'd1;
      end
   end

   logic       dec_reg_dst;
   logic       dec_alu_src;
   logic [1:0] dec_alu_op;
   logic       dec_mem_read;
   logic       dec_mem_write;
   logic       dec_mem_to_reg;
   logic       dec_reg_write;
   logic       dec_branch;
   logic       dec_done;
   logic       dec_illegal;

   always_comb begin
      dec_reg_dst    = 1'b0;
      dec_alu_src    = 1'b0;
      dec_alu_op     = 2'b00;
      dec_mem_read   = 1'b0;
      dec_mem_write  = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_reg_write  = 1'b0;
      dec_branch     = 1'b0;
      dec_done       = 1'b0;
      dec_illegal    = 1'b0;
      case (state)
         S_DECODE: begin
            dec_illegal = (op_q != OP_RTYPE) && (op_q != OP_LW) &&
                          (op_q != OP_SW) && (op_q != OP_BEQ);
         end
         S_RTYPE_EX: begin
            dec_reg_dst = 1'b1;
            dec_alu_op  = 2'b10;
         end
         S_RTYPE_WB: begin
            dec_reg_dst   = 1'b1;
            dec_alu_op    = 2'b10;
            dec_reg_write = 1'b1;
            dec_done      = 1'b1;
         end
         S_MEMADR: dec_alu_src = 1'b1;
         S_MEMRD: begin
            dec_alu_src  = 1'b1;
            dec_mem_read = 1'b1;
         end
         S_MEMWB: begin
            dec_mem_to_reg = 1'b1;
            dec_reg_write  = 1'b1;
            dec_done       = 1'b1;
         end
         S_MEMWR: begin
            dec_alu_src   = 1'b1;
            dec_mem_write = 1'b1;
            dec_done      = (wait_cnt == 4'd0);
         end
         S_BEQ_EX: begin
            dec_alu_op = 2'b01;
            dec_branch = 1'b1;
            dec_done   = 1'b1;
         end
         default: ;
      endcase
   end

   // Reset blanks every strobe combinationally, independent of the registered state.
   assign reg_dst    = !reset && dec_reg_dst;
   assign alu_src    = !reset && dec_alu_src;
   assign alu_op     = reset ? 2'b00 : dec_alu_op;
   assign mem_read   = !reset && dec_mem_read;
   assign mem_write  = !reset && dec_mem_write;
   assign mem_to_reg = !reset && dec_mem_to_reg;
   assign reg_write  = !reset && dec_reg_write;
   assign branch     = !reset && dec_branch;
   assign done       = !reset && dec_done;
   assign illegal    = !reset && dec_illegal;

`ifdef GFORCE_SEQ_RETIRE_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clock) begin
      if (reset)
         cnt_q <= '0;
      else if (done && !(&cnt_q))
         cnt_q <= cnt_q + 1'b1;
   end

   assign retired_cnt = reset ? '0 : cnt_q;
`else
   assign retired_cnt = '0;
`endif

endmodule
